uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
// - UART receiver, 8N1 default. Receive counterpart of uart_tx; same BIT_RATE/CLK_HZ/PAYLOAD_BITS/STOP_BITS parameter set.
// - Deserialises the board UART RX pin (Pin B18) into bytes so the host can send commands (e.g. register address / start-stop) to the MPU-6050 FSM.
// - Each accepted byte gives a 1-cycle valid pulse. Framing errors and line breaks are flagged, never delivered as data.
// PARAMETERS
// - BIT_RATE      115200       line baud rate
// - CLK_HZ        100_000_000  system clock frequency
// - PAYLOAD_BITS  8            data bits per frame, LSB first
// - STOP_BITS     1            stop bits checked per frame (1 or 2)
// - Derived: CPB = CLK_HZ/BIT_RATE (868). HALF = CPB/2 (434). Counter width = $clog2(CPB).
// PORTS
// - clk                input   1             system clock, single clock domain
// - resetn             input   1             asynchronous, active-low reset
// - uart_rxd           input   1             asynchronous serial line, idles high
// - uart_rx_en         input   1             1 = start bits may begin a new frame
// - uart_rx_valid      output  1             1-cycle pulse: uart_rx_data holds a new byte
// - uart_rx_data       output  PAYLOAD_BITS  last good byte, held until the next valid
// - uart_rx_frame_err  output  1             1-cycle pulse: a stop bit was sampled low
// - uart_rx_break      output  1             1-cycle pulse: frame error with all-zero data
// BEHAVIOUR
// - Reset: all outputs 0. FSM in IDLE. Synchroniser flops = 1. Counters and shift register 0. Reset is asynchronous at any point, including mid-frame; a partial frame is discarded.
// - Input path: 2-FF synchroniser gives rxd_s (2-cycle latency). All decisions use rxd_s only.
// - States (enum): IDLE, START, DATA, STOP, RECOVER. bit_cnt is cleared on entry to each state and after each sample.
// - IDLE: move to START when rxd_s==0 and uart_rx_en==1. Call this cycle t0.
// - START: sample at t0+HALF. If rxd_s==1, it was a glitch: go to IDLE with no output. Otherwise go to DATA.
// - DATA: bit i (0..PAYLOAD_BITS-1) is sampled at t0+HALF+(i+1)*CPB and shifted in LSB first. After the last bit, go to STOP.
// - STOP: stop bit k is sampled at t0+HALF+(PAYLOAD_BITS+1+k)*CPB.
//   - All stop bits 1: on the cycle after the last sample, uart_rx_valid=1 and uart_rx_data updates. Go to IDLE.
//   - Any stop bit 0: go to RECOVER right away. uart_rx_frame_err=1 for one cycle, plus uart_rx_break=1 if the shift register is all-zero. uart_rx_data is unchanged.
// - RECOVER: wait for rxd_s==1, then go to IDLE. A held-low line (break) gives exactly one error/break pulse.
// - Back-to-back frames: IDLE is entered mid stop bit, so a start edge right after the stop bit is caught. No idle gap is needed.
// - uart_rx_en only gates the IDLE->START move. Deasserting it mid-frame lets the current frame complete and report normally.
// - uart_rx_valid and uart_rx_frame_err are never high in the same cycle. There is no backpressure: the consumer must take data within one frame time.
// - Sampling tolerance: at most 2 cycles of synchroniser skew. Total baud mismatch within about ±4% must still decode correctly.
// STRUCTURE
// - uart_pkg (shared with uart_tx): typedef uart_rx_state_t, and function cycles_per_bit(CLK_HZ, BIT_RATE).
// - Sub-module sync_2ff: generic 2-flop synchroniser with parameter RESET_VAL (here 1'b1). Reusable for the MPU_SDA/SCL sampling paths.
// - uart_rx holds the FSM, the bit counter, the payload/stop bit index and the shift register. Outputs are registered. No latches.
// TESTING
// - Bench: behavioural UART driver with programmable baud. Scoreboard checks every output pulse.
// - 0x68 at 115200 -> exactly one valid pulse, uart_rx_data==8'h68. frame_err=0, break=0.
// - 200-cycle low glitch (< HALF), then 0xA5 -> no output for the glitch. One valid with 8'hA5.
// - 0x3C sent with stop bit forced 0 -> one frame_err pulse, valid=0, break=0. uart_rx_data stays 8'hA5.
// - Line held low for 20 bit times, then high, then 0x55 -> one frame_err and one break pulse only. Then one valid with 8'h55.
// - Reset asserted after data bit 3 of 0xF0, then 0xFF -> outputs 0 during reset. Only 0xFF is received.
// - Back-to-back 0x00,0xFF with no gap at +3% baud; uart_rx_en=0 during a third frame -> two valid pulses (8'h00, 8'hFF). Third frame ignored.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and bit-timing helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        RECOVER
    } uart_rx_state_t;

    // Clock cycles spent on one bit at the given line rate.
    function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for an asynchronous single-bit input.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture; both stages reset to the line's idle level.
    // NOTE: the reset is in the sensitivity list, so it acts asynchronously and
    // state is cleared even while the clock is stopped.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            // NOTE: non-blocking assignments give two real stages; blocking ones
            // would collapse the chain into a single flop.
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/stop decoding with framing-error and
// line-break detection. Accepted bytes are reported with a one-cycle valid.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BIT_RATE     = 115200,
    parameter int CLK_HZ       = 100_000_000,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic                    uart_rx_valid,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data,
    output logic                    uart_rx_frame_err,
    output logic                    uart_rx_break
);

    localparam int CPB     = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int HALF    = CPB / 2;
    localparam int CNT_W   = $clog2(CPB);
    localparam int IDX_MAX = (PAYLOAD_BITS > STOP_BITS) ? PAYLOAD_BITS : STOP_BITS;
    localparam int IDX_W   = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CPB - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(PAYLOAD_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    logic                    rxd_s;
    uart_rx_state_t          state, state_nxt;
    logic [CNT_W-1:0]        bit_cnt, bit_cnt_nxt;
    logic [IDX_W-1:0]        bit_idx, bit_idx_nxt;
    logic [PAYLOAD_BITS-1:0] shift, shift_nxt;
    logic                    valid_nxt;
    logic [PAYLOAD_BITS-1:0] data_nxt;
    logic                    frame_err_nxt;
    logic                    break_nxt;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (uart_rxd),
        .q      (rxd_s)
    );

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, counter, shift-register and output decode.
    // NOTE: every signal gets a default before the case, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt + CNT_W'(1);
        bit_idx_nxt   = bit_idx;
        shift_nxt     = shift;
        valid_nxt     = 1'b0;
        data_nxt      = uart_rx_data;
        frame_err_nxt = 1'b0;
        break_nxt     = 1'b0;

        case (state)
            IDLE: begin
                bit_cnt_nxt = '0;
                bit_idx_nxt = '0;
                if (!rxd_s && uart_rx_en) begin
                    state_nxt = START;
                end
            end

            // Re-check the start bit at its centre to reject short glitches.
            START: begin
                if (bit_cnt == HALF_LAST) begin
                    bit_cnt_nxt = '0;
                    state_nxt   = rxd_s ? IDLE : DATA;
                end
            end

            DATA: begin
                if (bit_cnt == FULL_LAST) begin
                    bit_cnt_nxt = '0;
                    shift_nxt   = {rxd_s, shift[PAYLOAD_BITS-1:1]};
                    if (bit_idx == DATA_LAST) begin
                        bit_idx_nxt = '0;
                        state_nxt   = STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + IDX_W'(1);
                    end
                end
            end

            // Leaving at the centre of the last stop bit lets IDLE catch a
            // start edge that follows immediately.
            STOP: begin
                if (bit_cnt == FULL_LAST) begin
                    bit_cnt_nxt = '0;
                    if (!rxd_s) begin
                        bit_idx_nxt   = '0;
                        frame_err_nxt = 1'b1;
                        break_nxt     = (shift == '0);
                        state_nxt     = RECOVER;
                    end else if (bit_idx == STOP_LAST) begin
                        bit_idx_nxt = '0;
                        valid_nxt   = 1'b1;
                        data_nxt    = shift;
                        state_nxt   = IDLE;
                    end else begin
                        bit_idx_nxt = bit_idx + IDX_W'(1);
                    end
                end
            end

            // Hold off until the line returns high so a break reports once.
            RECOVER: begin
                bit_cnt_nxt = '0;
                if (rxd_s) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bit_cnt           <= '0;
            bit_idx           <= '0;
            shift             <= '0;
            uart_rx_valid     <= 1'b0;
            uart_rx_data      <= '0;
            uart_rx_frame_err <= 1'b0;
            uart_rx_break     <= 1'b0;
        end else begin
            bit_cnt           <= bit_cnt_nxt;
            bit_idx           <= bit_idx_nxt;
            shift             <= shift_nxt;
            uart_rx_valid     <= valid_nxt;
            uart_rx_data      <= data_nxt;
            uart_rx_frame_err <= frame_err_nxt;
            uart_rx_break     <= break_nxt;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: behavioural line driver with programmable bit period,
// a pulse monitor, and directed plus randomised frame scenarios.
module tb_uart_rx;

    // Clock scaled so one bit is 64 cycles, keeping runs short.
    localparam int BIT_RATE     = 115200;
    localparam int CPB_TB       = 64;
    localparam int CLK_HZ       = BIT_RATE * CPB_TB;
    localparam int PAYLOAD_BITS = 8;
    localparam int STOP_BITS    = 1;
    localparam int HALF_TB      = CPB_TB / 2;
    localparam int FAST_BIT     = 62;   // about +3% line rate
    localparam int SLOW_BIT     = 66;   // about -3% line rate

    logic       clk        = 1'b0;
    logic       resetn     = 1'b0;
    logic       uart_rxd   = 1'b1;
    logic       uart_rx_en = 1'b0;
    logic       uart_rx_valid;
    logic [7:0] uart_rx_data;
    logic       uart_rx_frame_err;
    logic       uart_rx_break;

    int checks   = 0;
    int failures = 0;

    // Monitor log, written only by the monitor process.
    logic [7:0] rx_log[$];
    int ferr_cnt    = 0;
    int brk_cnt     = 0;
    int lone_brk    = 0;
    int overlap_cnt = 0;

    uart_rx #(
        .BIT_RATE     (BIT_RATE),
        .CLK_HZ       (CLK_HZ),
        .PAYLOAD_BITS (PAYLOAD_BITS),
        .STOP_BITS    (STOP_BITS)
    ) dut (
        .clk               (clk),
        .resetn            (resetn),
        .uart_rxd          (uart_rxd),
        .uart_rx_en        (uart_rx_en),
        .uart_rx_valid     (uart_rx_valid),
        .uart_rx_data      (uart_rx_data),
        .uart_rx_frame_err (uart_rx_frame_err),
        .uart_rx_break     (uart_rx_break)
    );

    always #5 clk = ~clk;

    // Record every output pulse on the falling edge.
    always @(negedge clk) begin
        if (resetn) begin
            if (uart_rx_valid) rx_log.push_back(uart_rx_data);
            if (uart_rx_frame_err) ferr_cnt++;
            if (uart_rx_break) brk_cnt++;
            if (uart_rx_break && !uart_rx_frame_err) lone_brk++;
            if (uart_rx_valid && uart_rx_frame_err) overlap_cnt++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_level(input logic v, input int n);
        uart_rxd = v;
        repeat (n) @(negedge clk);
    endtask

    // One frame: start, LSB-first data, stop bits at the given level.
    task automatic send_frame(input logic [7:0] b, input int period,
                              input logic stop_val, input bit drop_en);
        drive_level(1'b0, period);
        if (drop_en) uart_rx_en = 1'b0;
        for (int i = 0; i < PAYLOAD_BITS; i++) drive_level(b[i], period);
        for (int k = 0; k < STOP_BITS; k++) drive_level(stop_val, period);
        uart_rxd = 1'b1;
    endtask

    task automatic test_reset;
        repeat (5) @(negedge clk);
        checks++;
        if ({uart_rx_valid, uart_rx_data, uart_rx_frame_err, uart_rx_break} !== 11'd0) begin
            failures++;
            $display("FAIL reset_outputs: got v=%b d=%h fe=%b br=%b required all 0",
                     uart_rx_valid, uart_rx_data, uart_rx_frame_err, uart_rx_break);
        end
        resetn     = 1'b1;
        uart_rx_en = 1'b1;
        idle(20);
        checks++;
        if (rx_log.size() !== 0 || ferr_cnt !== 0 || brk_cnt !== 0) begin
            failures++;
            $display("FAIL reset_idle: got valid=%0d ferr=%0d brk=%0d required 0 0 0",
                     rx_log.size(), ferr_cnt, brk_cnt);
        end
    endtask

    task automatic test_single;
        int n0 = rx_log.size();
        int f0 = ferr_cnt;
        int b0 = brk_cnt;
        send_frame(8'h68, CPB_TB, 1'b1, 1'b0);
        idle(8);
        checks++;
        if (rx_log.size() - n0 !== 1) begin
            failures++;
            $display("FAIL single_count: got %0d valid pulses required 1", rx_log.size() - n0);
        end else begin
            checks++;
            if (rx_log[n0] !== 8'h68) begin
                failures++;
                $display("FAIL single_data: got %h required 68", rx_log[n0]);
            end
        end
        checks++;
        if (ferr_cnt - f0 !== 0 || brk_cnt - b0 !== 0) begin
            failures++;
            $display("FAIL single_err: got ferr=%0d brk=%0d required 0 0", ferr_cnt - f0, brk_cnt - b0);
        end
        checks++;
        if (uart_rx_data !== 8'h68) begin
            failures++;
            $display("FAIL single_hold: got %h required 68", uart_rx_data);
        end
    endtask

    task automatic test_glitch;
        int n0 = rx_log.size();
        int f0 = ferr_cnt;
        drive_level(1'b0, HALF_TB - 17);
        drive_level(1'b1, 2 * CPB_TB);
        checks++;
        if (rx_log.size() - n0 !== 0 || ferr_cnt - f0 !== 0) begin
            failures++;
            $display("FAIL glitch_silent: got valid=%0d ferr=%0d required 0 0",
                     rx_log.size() - n0, ferr_cnt - f0);
        end
        send_frame(8'hA5, CPB_TB, 1'b1, 1'b0);
        idle(8);
        checks++;
        if (rx_log.size() - n0 !== 1) begin
            failures++;
            $display("FAIL glitch_count: got %0d valid pulses required 1", rx_log.size() - n0);
        end else begin
            checks++;
            if (rx_log[n0] !== 8'hA5) begin
                failures++;
                $display("FAIL glitch_data: got %h required a5", rx_log[n0]);
            end
        end
    endtask

    task automatic test_stop_err;
        int n0 = rx_log.size();
        int f0 = ferr_cnt;
        int b0 = brk_cnt;
        send_frame(8'h3C, CPB_TB, 1'b0, 1'b0);
        idle(CPB_TB);
        checks++;
        if (ferr_cnt - f0 !== 1 || brk_cnt - b0 !== 0) begin
            failures++;
            $display("FAIL stoperr_flags: got ferr=%0d brk=%0d required 1 0", ferr_cnt - f0, brk_cnt - b0);
        end
        checks++;
        if (rx_log.size() - n0 !== 0) begin
            failures++;
            $display("FAIL stoperr_valid: got %0d valid pulses required 0", rx_log.size() - n0);
        end
        checks++;
        if (uart_rx_data !== 8'hA5) begin
            failures++;
            $display("FAIL stoperr_hold: got %h required a5", uart_rx_data);
        end
    endtask

    task automatic test_break;
        int n0 = rx_log.size();
        int f0 = ferr_cnt;
        int b0 = brk_cnt;
        drive_level(1'b0, 20 * CPB_TB);
        drive_level(1'b1, 2 * CPB_TB);
        checks++;
        if (ferr_cnt - f0 !== 1 || brk_cnt - b0 !== 1) begin
            failures++;
            $display("FAIL break_flags: got ferr=%0d brk=%0d required 1 1", ferr_cnt - f0, brk_cnt - b0);
        end
        checks++;
        if (rx_log.size() - n0 !== 0) begin
            failures++;
            $display("FAIL break_valid: got %0d valid pulses required 0", rx_log.size() - n0);
        end
        send_frame(8'h55, CPB_TB, 1'b1, 1'b0);
        idle(8);
        checks++;
        if (rx_log.size() - n0 !== 1) begin
            failures++;
            $display("FAIL break_after_count: got %0d valid pulses required 1", rx_log.size() - n0);
        end else begin
            checks++;
            if (rx_log[n0] !== 8'h55) begin
                failures++;
                $display("FAIL break_after_data: got %h required 55", rx_log[n0]);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        int n0 = rx_log.size();
        int f0 = ferr_cnt;
        logic [7:0] partial = 8'hF0;
        drive_level(1'b0, CPB_TB);
        for (int i = 0; i < 4; i++) drive_level(partial[i], CPB_TB);
        drive_level(1'b1, CPB_TB / 4);
        resetn   = 1'b0;
        uart_rxd = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({uart_rx_valid, uart_rx_data, uart_rx_frame_err, uart_rx_break} !== 11'd0) begin
                failures++;
                $display("FAIL midreset_outputs: got v=%b d=%h fe=%b br=%b required all 0",
                         uart_rx_valid, uart_rx_data, uart_rx_frame_err, uart_rx_break);
            end
        end
        resetn = 1'b1;
        idle(2 * CPB_TB);
        send_frame(8'hFF, CPB_TB, 1'b1, 1'b0);
        idle(8);
        checks++;
        if (rx_log.size() - n0 !== 1 || ferr_cnt - f0 !== 0) begin
            failures++;
            $display("FAIL midreset_count: got valid=%0d ferr=%0d required 1 0",
                     rx_log.size() - n0, ferr_cnt - f0);
        end else begin
            checks++;
            if (rx_log[n0] !== 8'hFF) begin
                failures++;
                $display("FAIL midreset_data: got %h required ff", rx_log[n0]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int n0 = rx_log.size();
        int f0 = ferr_cnt;
        send_frame(8'h00, FAST_BIT, 1'b1, 1'b0);
        send_frame(8'hFF, FAST_BIT, 1'b1, 1'b1);   // enable dropped mid-frame
        send_frame(8'h96, FAST_BIT, 1'b1, 1'b0);   // must be ignored
        idle(CPB_TB);
        uart_rx_en = 1'b1;
        idle(CPB_TB);
        checks++;
        if (rx_log.size() - n0 !== 2 || ferr_cnt - f0 !== 0) begin
            failures++;
            $display("FAIL b2b_count: got valid=%0d ferr=%0d required 2 0",
                     rx_log.size() - n0, ferr_cnt - f0);
        end else begin
            checks++;
            if (rx_log[n0] !== 8'h00 || rx_log[n0+1] !== 8'hFF) begin
                failures++;
                $display("FAIL b2b_data: got %h %h required 00 ff", rx_log[n0], rx_log[n0+1]);
            end
        end
    endtask

    // Random bytes, bit periods within +-3%, occasional bad stop bits.
    task automatic test_random;
        logic [7:0] exp_q[$];
        int exp_ferr = 0;
        int exp_brk  = 0;
        int n0 = rx_log.size();
        int f0 = ferr_cnt;
        int b0 = brk_cnt;
        for (int f = 0; f < 12; f++) begin
            logic [7:0] b;
            int         period;
            logic       stop_ok;
            b       = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            period  = $urandom_range(FAST_BIT, SLOW_BIT);
            stop_ok = ($urandom_range(0, 3) != 0);
            if (stop_ok) begin
                exp_q.push_back(b);
            end else begin
                exp_ferr++;
                if (b == 8'h00) exp_brk++;
            end
            send_frame(b, period, stop_ok, 1'b0);
            idle(stop_ok ? $urandom_range(0, 5) : CPB_TB);
        end
        idle(CPB_TB);
        checks++;
        if (rx_log.size() - n0 !== exp_q.size()) begin
            failures++;
            $display("FAIL random_count: got %0d valid pulses required %0d",
                     rx_log.size() - n0, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (rx_log[n0+i] !== exp_q[i]) begin
                    failures++;
                    $display("FAIL random_data[%0d]: got %h required %h", i, rx_log[n0+i], exp_q[i]);
                end
            end
        end
        checks++;
        if (ferr_cnt - f0 !== exp_ferr || brk_cnt - b0 !== exp_brk) begin
            failures++;
            $display("FAIL random_err: got ferr=%0d brk=%0d required %0d %0d",
                     ferr_cnt - f0, brk_cnt - b0, exp_ferr, exp_brk);
        end
    endtask

    task automatic test_pulse_rules;
        checks++;
        if (overlap_cnt !== 0) begin
            failures++;
            $display("FAIL valid_err_overlap: got %0d cycles required 0", overlap_cnt);
        end
        checks++;
        if (lone_brk !== 0) begin
            failures++;
            $display("FAIL break_without_err: got %0d cycles required 0", lone_brk);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_glitch();
        test_stop_err();
        test_break();
        test_reset_mid_frame();
        test_back_to_back();
        test_random();
        test_pulse_rules();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
